// File: rtl/arilla_bus_arbiter.sv
// Round-robin owner arbiter for the shared arilla bus.
// Grants one master at a time. A grant is held while that master keeps req high.
// On release, the next requester found from the rotated pointer is granted at the same edge.
// Optional watchdog: define ARILLA_ARB_TIMEOUT_EN to revoke a grant after MaxHold cycles.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req         per-master request, held for the whole transaction
//   available   per-master grant, one-hot or zero (registered)
//   grant_valid any grant active (registered)
//   grant_id    index of the current owner, 0 when idle (registered)
//   timeout     one-cycle pulse when the watchdog revokes a grant (registered)
module arilla_bus_arbiter #(
    parameter int unsigned NumMasters = 2,
    parameter int unsigned IdWidth    = (NumMasters > 1) ? $clog2(NumMasters) : 1,
    parameter int unsigned MaxHold    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NumMasters-1:0] req,
    output logic [NumMasters-1:0] available,
    output logic                  grant_valid,
    output logic [IdWidth-1:0]    grant_id,
    output logic                  timeout
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                state_q, state_d;
    logic [NumMasters-1:0] available_d;
    logic                  grant_valid_d;
    logic [IdWidth-1:0]    grant_id_d;
    logic                  timeout_d;
    logic [IdWidth-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0]    grant_sel;

`ifdef ARILLA_ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MaxHold + 1);
    logic [HoldW-1:0] hold_q, hold_d;
`endif

    // First requester at or above ptr; wraps to the lowest requester otherwise.
    function automatic logic [IdWidth-1:0] rr_pick(input logic [NumMasters-1:0] r,
                                                   input logic [IdWidth-1:0]    ptr);
        logic [IdWidth-1:0] low_any;
        logic [IdWidth-1:0] low_above;
        logic               found_above;
        low_any     = '0;
        low_above   = '0;
        found_above = 1'b0;
        for (int j = int'(NumMasters) - 1; j >= 0; j--) begin
            if (r[j]) begin
                low_any = IdWidth'(j);
                if (IdWidth'(j) >= ptr) begin
                    low_above   = IdWidth'(j);
                    found_above = 1'b1;
                end
            end
        end
        return found_above ? low_above : low_any;
    endfunction

    function automatic logic [IdWidth-1:0] next_idx(input logic [IdWidth-1:0] o);
        return (o == IdWidth'(NumMasters - 1)) ? '0 : o + IdWidth'(1);
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        available_d   = available;
        grant_valid_d = grant_valid;
        grant_id_d    = grant_id;
        timeout_d     = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        grant_sel     = '0;
`ifdef ARILLA_ARB_TIMEOUT_EN
        hold_d        = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_sel     = rr_pick(req, rr_ptr_q);
                    state_d       = OWNED;
                    available_d   = NumMasters'(1) << grant_sel;
                    grant_valid_d = 1'b1;
                    grant_id_d    = grant_sel;
`ifdef ARILLA_ARB_TIMEOUT_EN
                    hold_d        = '0;
`endif
                end
            end
            OWNED: begin
                if (!req[grant_id]) begin
                    // Release: rotate past the owner and hand over at the same edge if possible.
                    rr_ptr_d = next_idx(grant_id);
                    if (|req) begin
                        grant_sel     = rr_pick(req, next_idx(grant_id));
                        available_d   = NumMasters'(1) << grant_sel;
                        grant_valid_d = 1'b1;
                        grant_id_d    = grant_sel;
`ifdef ARILLA_ARB_TIMEOUT_EN
                        hold_d        = '0;
`endif
                    end else begin
                        state_d       = IDLE;
                        available_d   = '0;
                        grant_valid_d = 1'b0;
                        grant_id_d    = '0;
                    end
                end
`ifdef ARILLA_ARB_TIMEOUT_EN
                else if (hold_q == HoldW'(MaxHold - 1)) begin
                    // Watchdog revoke: one dead cycle, then the owner re-competes.
                    rr_ptr_d      = next_idx(grant_id);
                    state_d       = IDLE;
                    available_d   = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    timeout_d     = 1'b1;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            available   <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout     <= 1'b0;
            rr_ptr_q    <= '0;
`ifdef ARILLA_ARB_TIMEOUT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            available   <= available_d;
            grant_valid <= grant_valid_d;
            grant_id    <= grant_id_d;
            timeout     <= timeout_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ARILLA_ARB_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    // Single owner on the bus and a consistent valid flag.
    assert property (@(posedge clk) disable iff (rst)
                     $onehot0(available) && (grant_valid == |available));

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed bench for arilla_bus_arbiter with three masters and MaxHold=4.
module tb_arilla_bus_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  available;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic          timeout;

    int checks;
    int failures;

    arilla_bus_arbiter #(
        .NumMasters(N),
        .IdWidth   (IW),
        .MaxHold   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .available  (available),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs just after a falling edge; the next falling edge shows the registered result.
    task automatic step(input logic r_rst, input logic [N-1:0] r_req);
        rst = r_rst;
        req = r_req;
        @(negedge clk);
    endtask

    task automatic expect_grant(input string tag, input logic [N-1:0] a,
                                input logic [IW-1:0] id, input logic to);
        check({tag, ".available"},   32'(available),   32'(a));
        check({tag, ".grant_valid"}, 32'(grant_valid), 32'(|a));
        check({tag, ".grant_id"},    32'(grant_id),    32'(id));
        check({tag, ".timeout"},     32'(timeout),     32'(to));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 3'b011;
        @(negedge clk);

        // Reset holds everything low even with requests pending.
        step(1'b1, 3'b011); expect_grant("rst0", 3'b000, 2'd0, 1'b0);
        step(1'b1, 3'b011); expect_grant("rst1", 3'b000, 2'd0, 1'b0);
        step(1'b0, 3'b011); expect_grant("rst_rel", 3'b001, 2'd0, 1'b0);
        step(1'b0, 3'b000); expect_grant("idle0", 3'b000, 2'd0, 1'b0);

        // Single two-cycle read by master 1.
        step(1'b0, 3'b010); expect_grant("rd_a", 3'b010, 2'd1, 1'b0);
        step(1'b0, 3'b010); expect_grant("rd_b", 3'b010, 2'd1, 1'b0);
        step(1'b0, 3'b000); expect_grant("rd_end", 3'b000, 2'd0, 1'b0);

        // Re-align the pointer, then full contention with rotation 0,1,2,0.
        step(1'b1, 3'b000); expect_grant("rst2", 3'b000, 2'd0, 1'b0);
        step(1'b0, 3'b111); expect_grant("rot0a", 3'b001, 2'd0, 1'b0);
        step(1'b0, 3'b111); expect_grant("rot0b", 3'b001, 2'd0, 1'b0);
        step(1'b0, 3'b110); expect_grant("rot1a", 3'b010, 2'd1, 1'b0);
        step(1'b0, 3'b111); expect_grant("rot1b", 3'b010, 2'd1, 1'b0);
        step(1'b0, 3'b101); expect_grant("rot2a", 3'b100, 2'd2, 1'b0);
        step(1'b0, 3'b111); expect_grant("rot2b", 3'b100, 2'd2, 1'b0);
        step(1'b0, 3'b011); expect_grant("rot0c", 3'b001, 2'd0, 1'b0);

        // Owner 0 holds while master 1 pulses its request.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i >= 3 && i <= 5) ? 3'b011 : 3'b001);
            expect_grant("hold", 3'b001, 2'd0, 1'b0);
        end
        step(1'b0, 3'b010); expect_grant("handover", 3'b010, 2'd1, 1'b0);
        step(1'b0, 3'b000); expect_grant("idle1", 3'b000, 2'd0, 1'b0);

        // Reset in the middle of a read, then regrant.
        step(1'b0, 3'b010); expect_grant("mid_a", 3'b010, 2'd1, 1'b0);
        step(1'b1, 3'b010); expect_grant("mid_rst", 3'b000, 2'd0, 1'b0);
        step(1'b0, 3'b010); expect_grant("mid_regrant", 3'b010, 2'd1, 1'b0);
        step(1'b0, 3'b000); expect_grant("mid_end", 3'b000, 2'd0, 1'b0);

        // Released master is last in the scan but still wins when alone.
        step(1'b0, 3'b010); expect_grant("solo", 3'b010, 2'd1, 1'b0);
        step(1'b0, 3'b000); expect_grant("solo_end", 3'b000, 2'd0, 1'b0);

        // Master 0 stuck requesting while master 1 waits.
        step(1'b0, 3'b011); expect_grant("to_grant", 3'b001, 2'd0, 1'b0);
`ifdef ARILLA_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b011);
            expect_grant("to_hold", 3'b001, 2'd0, 1'b0);
        end
        step(1'b0, 3'b011); expect_grant("to_revoke", 3'b000, 2'd0, 1'b1);
        step(1'b0, 3'b011); expect_grant("to_next", 3'b010, 2'd1, 1'b0);
`else
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'b011);
            expect_grant("to_hold", 3'b001, 2'd0, 1'b0);
        end
`endif
        step(1'b0, 3'b000); expect_grant("to_end", 3'b000, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
